// File: rtl/rgst_deser.sv
`default_nettype none
// ============================================================================
//  Module      : rgst_deser
//  Description : Reader-side controller for a shifting register. Drives the
//                register's shift-left (MSB-first) or shift-right (LSB-first)
//                enable for w cycles. Captures the serial bit presented on the
//                register's msb/lsb output and rebuilds the word in its
//                original bit order. Offers the word downstream through a
//                valid/ready handshake.
//  Options     : `define RGST_DESER_HOLD_EN adds a 'hold' input that pauses
//                a running transfer without losing collected bits.
//  Revision    : 1.0  initial release
// ============================================================================
module rgst_deser #(
  parameter int w  = 8,   // word width, must equal the source register width
  parameter int CW = 4    // bit-counter width, 2**CW > w
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic          start,
  input  logic          dir,
  input  logic          bit_in,
  input  logic          out_rdy,
`ifdef RGST_DESER_HOLD_EN
  input  logic          hold,
`endif
  output logic          shl,
  output logic          shr,
  output logic [w-1:0]  q,
  output logic          q_vld,
  output logic          busy,
  output logic [CW-1:0] cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(w - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_q;
  logic          dir_q;
  logic [w-1:0]  word_q;
  logic [CW-1:0] cnt_q;
  logic          vld_q;
  logic          adv;

  // A bit moves this cycle only while running (and not paused, when enabled)
`ifdef RGST_DESER_HOLD_EN
  assign adv = (state_q == S_RUN) && !hold;
`else
  assign adv = (state_q == S_RUN);
`endif

  // Shift enables follow the latched direction; they can never both be high
  assign shl   = adv && !dir_q;
  assign shr   = adv &&  dir_q;
  assign q     = word_q;
  assign q_vld = vld_q;
  assign cnt   = cnt_q;
  assign busy  = (state_q != S_IDLE);

  // Transfer FSM: reset, then clear, then normal sequencing
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      word_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else if (clr) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dir_q   <= dir;
            word_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (adv) begin
            // MSB-first fills from the right, LSB-first fills from the left,
            // so the word lands in its original order either way
            if (dir_q) begin
              word_q <= {bit_in, word_q[w-1:1]};
            end else begin
              word_q <= {word_q[w-2:0], bit_in};
            end
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
              state_q <= S_DONE;
              vld_q   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Word stays in q after hand-off; only the valid flag drops
          if (out_rdy) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          vld_q   <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgst_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgst_deser
//  Description : Self-checking bench for rgst_deser with a behavioural source
//                register feeding bit_in.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rgst_deser;

  logic       clk = 1'b0;
  logic       rst_b, clr, start, dir, out_rdy;
  logic       bit_in;
  logic       shl, shr, q_vld, busy;
  logic [7:0] q;
  logic [3:0] cnt;
`ifdef RGST_DESER_HOLD_EN
  logic       hold;
`endif

  // Source register environment
  logic [7:0] src;
  logic       src_ld;
  logic [7:0] src_val;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rgst_deser #(.w(8), .CW(4)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (clr),
    .start   (start),
    .dir     (dir),
    .bit_in  (bit_in),
    .out_rdy (out_rdy),
`ifdef RGST_DESER_HOLD_EN
    .hold    (hold),
`endif
    .shl     (shl),
    .shr     (shr),
    .q       (q),
    .q_vld   (q_vld),
    .busy    (busy),
    .cnt     (cnt)
  );

  // Source register: parallel load, or shift with zero fill when enabled
  always @(posedge clk) begin
    if (src_ld)   src <= src_val;
    else if (shl) src <= {src[6:0], 1'b0};
    else if (shr) src <= {1'b0, src[7:1]};
  end
  assign bit_in = shr ? src[0] : src[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    src_ld  = 1'b1;
    src_val = v;
    step();
    src_ld  = 1'b0;
  endtask

  // One full transfer; the expected word is simply the word loaded into the
  // source, and the expected timing is w shift cycles then a valid word.
  task automatic xfer(input logic [7:0] word, input logic d, input logic rdy, input string tag);
    int nsl, nsr, cyc;
    load(word);
    out_rdy = rdy;
    dir     = d;
    start   = 1'b1;
    step();
    start   = 1'b0;
    chk({tag, " busy0"}, 32'(busy), 1);
    chk({tag, " cnt0"},  32'(cnt), 0);
    nsl = 0; nsr = 0; cyc = 0;
    while (!q_vld && cyc < 40) begin
      chk({tag, " excl"}, 32'(shl & shr), 0);
      nsl += int'(shl);
      nsr += int'(shr);
      // noise on start/dir during RUN must not disturb the transfer
      start = 1'($urandom_range(0, 1));
      dir   = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    start = 1'b0;
    dir   = d;
    chk({tag, " vld"},    32'(q_vld), 1);
    chk({tag, " cycles"}, 32'(cyc), 8);
    chk({tag, " nshl"},   32'(nsl), d ? 0 : 8);
    chk({tag, " nshr"},   32'(nsr), d ? 8 : 0);
    chk({tag, " q"},      32'(q), 32'(word));
    chk({tag, " cnt"},    32'(cnt), 8);
    chk({tag, " srcdrn"}, 32'(src), 0);
    chk({tag, " shdone"}, 32'({shl, shr}), 0);
    if (!rdy) begin
      repeat (3) begin
        start = 1'($urandom_range(0, 1));
        step();
        chk({tag, " hold vld"}, 32'(q_vld), 1);
        chk({tag, " hold q"},   32'(q), 32'(word));
      end
      start   = 1'b1;
      out_rdy = 1'b1;
    end
    step();
    start = 1'b0;
    chk({tag, " idle busy"}, 32'(busy), 0);
    chk({tag, " idle vld"},  32'(q_vld), 0);
    chk({tag, " idle cnt"},  32'(cnt), 0);
    chk({tag, " keep q"},    32'(q), 32'(word));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0; clr = 1'b0; start = 1'b0; dir = 1'b0; out_rdy = 1'b0;
    src_ld = 1'b0; src_val = 8'h00;
`ifdef RGST_DESER_HOLD_EN
    hold = 1'b0;
`endif
    #2;
    chk("rst q",    32'(q), 0);
    chk("rst vld",  32'(q_vld), 0);
    chk("rst sh",   32'({shl, shr}), 0);
    chk("rst cnt",  32'(cnt), 0);
    chk("rst busy", 32'(busy), 0);
    step();
    rst_b = 1'b1;
    step();

    // Directed transfers
    xfer(8'hB4, 1'b0, 1'b1, "msb B4");
    xfer(8'h2D, 1'b1, 1'b0, "lsb 2D");
    xfer(8'h5A, 1'b0, 1'b1, "b2b 5A");
    xfer(8'hA5, 1'b1, 1'b1, "b2b A5");

    // Abort after three bits
    load(8'hFF);
    dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("abort cnt3", 32'(cnt), 3);
    chk("abort q3",   32'(q), 32'h07);
    clr = 1'b1;
    step();
    chk("abort busy", 32'(busy), 0);
    chk("abort q",    32'(q), 0);
    chk("abort shl",  32'(shl), 0);
    chk("abort cnt",  32'(cnt), 0);
    chk("abort vld",  32'(q_vld), 0);
    start = 1'b1;
    step();
    chk("clr+start busy", 32'(busy), 0);
    clr = 1'b0; start = 1'b0;
    step();

    // Random transfers
    for (int i = 0; i < 6; i++) begin
      xfer(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

`ifdef RGST_DESER_HOLD_EN
    begin
      int nsl, cyc;
      load(8'hC3);
      dir = 1'b0; start = 1'b1; out_rdy = 1'b1;
      step();
      start = 1'b0;
      nsl = 0; cyc = 0;
      repeat (4) begin nsl += int'(shl); step(); cyc++; end
      hold = 1'b1;
      #1;
      chk("hold shl", 32'(shl), 0);
      chk("hold cnt", 32'(cnt), 4);
      repeat (2) begin nsl += int'(shl); step(); cyc++; end
      chk("hold cnt2", 32'(cnt), 4);
      hold = 1'b0;
      while (!q_vld && cyc < 40) begin nsl += int'(shl); step(); cyc++; end
      chk("hold vld",  32'(q_vld), 1);
      chk("hold cyc",  32'(cyc), 10);
      chk("hold nshl", 32'(nsl), 8);
      chk("hold q",    32'(q), 32'hC3);
      step();
    end
`endif

    // Asynchronous reset mid-transfer
    load(8'h99);
    dir = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst q",    32'(q), 0);
    chk("arst vld",  32'(q_vld), 0);
    chk("arst sh",   32'({shl, shr}), 0);
    chk("arst cnt",  32'(cnt), 0);
    chk("arst busy", 32'(busy), 0);
    step();
    rst_b = 1'b1;
    step();
    xfer(8'h3C, 1'b0, 1'b1, "post rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
